universal_register: RTL and testbench

Parametrised successor to the single-bit clearable D flip-flop: a WIDTH-bit register with asynchronous active-low clear, synchronous clear, clock enable and eight operating modes (hold, load, shift, rotate, increment, decrement). Carry/borrow is registered. A zero flag is provided. Used as the CPU's accumulator, general-purpose register, program counter or shift register, all from one primitive.

---
 rtl/universal_register_if.sv | 25 ++
 rtl/universal_register.sv | 78 +++++++
 tb/tb_universal_register.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/universal_register_if.sv
// Control and data bundle for universal_register: the bench drives through master,
// the register sits on slave. There is no handshake; controls are sampled at each rising clock edge.
interface universal_register_if #(
    parameter int WIDTH = 8
);
    logic             sync_clear;
    logic             enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             serial_in_lsb;
    logic             serial_in_msb;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             zero_out;

    modport master (
        output sync_clear, enable, mode, data_in, serial_in_lsb, serial_in_msb,
        input  data_out, carry_out, zero_out
    );

    modport slave (
        input  sync_clear, enable, mode, data_in, serial_in_lsb, serial_in_msb,
        output data_out, carry_out, zero_out
    );
endinterface

// File: rtl/universal_register.sv
// WIDTH-bit multi-mode register: load, shift, rotate, increment and decrement,
// with a registered carry/borrow bit and a combinational zero flag.
module universal_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic          clock,
    input  logic          clear_n,
    universal_register_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_INC   = 3'b110,
        MODE_DEC   = 3'b111
    } mode_t;

    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;

    always_comb begin
        data_d  = data_q;
        carry_d = carry_q;
        if (bus.sync_clear) begin
            data_d  = RESET_VALUE;
            carry_d = 1'b0;
        end else if (bus.enable) begin
            case (mode_t'(bus.mode))
                MODE_HOLD: ;
                MODE_LOAD: begin
                    data_d  = bus.data_in;
                    carry_d = 1'b0;
                end
                MODE_SHL: begin
                    data_d  = {data_q[WIDTH-2:0], bus.serial_in_lsb};
                    carry_d = data_q[WIDTH-1];
                end
                MODE_SHR: begin
                    data_d  = {bus.serial_in_msb, data_q[WIDTH-1:1]};
                    carry_d = data_q[0];
                end
                MODE_ROL: begin
                    data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    carry_d = data_q[WIDTH-1];
                end
                MODE_ROR: begin
                    data_d  = {data_q[0], data_q[WIDTH-1:1]};
                    carry_d = data_q[0];
                end
                // Carry is the bit above the register in a WIDTH+1-bit sum.
                MODE_INC: {carry_d, data_d} = {1'b0, data_q} + (WIDTH+1)'(1);
                MODE_DEC: begin
                    data_d  = data_q - WIDTH'(1);
                    carry_d = (data_q == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            data_q  <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.zero_out  = (data_q == '0);
endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: directed vector table, random run against an
// arithmetic reference model, and asynchronous-clear corner cases on two reset values.
module tb_universal_register;
    localparam int W = 8;

    logic clock;
    logic clear_n;

    universal_register_if #(.WIDTH(W)) bus0 ();
    universal_register_if #(.WIDTH(W)) bus80 ();

    universal_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut0 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus0.slave)
    );

    universal_register #(.WIDTH(W), .RESET_VALUE(8'h80)) dut80 (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus80.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    logic [W-1:0] exp_q[$];

    // reference model state for both instances
    int m0, c0, m80, c80;

    typedef struct {
        logic       sc;
        logic       en;
        logic [2:0] md;
        logic [7:0] din;
        logic       sl;
        logic       sm;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: plain integer arithmetic modulo 256.
    function automatic void model_step(input int v, input int c, input int sc, input int en,
                                       input int md, input int din, input int sl, input int sm,
                                       input int rv, output int nv, output int nc);
        nv = v;
        nc = c;
        if (sc != 0) begin
            nv = rv; nc = 0;
        end else if (en != 0) begin
            case (md)
                1: begin nv = din; nc = 0; end
                2: begin nv = (v * 2 + sl) % 256;      nc = v / 128; end
                3: begin nv = v / 2 + sm * 128;        nc = v % 2;   end
                4: begin nv = (v * 2) % 256 + v / 128; nc = v / 128; end
                5: begin nv = v / 2 + (v % 2) * 128;   nc = v % 2;   end
                6: begin nv = (v + 1) % 256; nc = (v + 1) / 256; end
                7: begin nv = (v + 255) % 256; nc = (v == 0) ? 1 : 0; end
                default: ;
            endcase
        end
    endfunction

    // driver: drive at falling edge, update models, return #1 after rising edge
    task automatic apply(input logic sc, input logic en, input logic [2:0] md,
                         input logic [7:0] din, input logic sl, input logic sm);
        int nv, nc;
        @(negedge clock);
        bus0.sync_clear = sc;   bus80.sync_clear = sc;
        bus0.enable = en;       bus80.enable = en;
        bus0.mode = md;         bus80.mode = md;
        bus0.data_in = din;     bus80.data_in = din;
        bus0.serial_in_lsb = sl; bus80.serial_in_lsb = sl;
        bus0.serial_in_msb = sm; bus80.serial_in_msb = sm;
        model_step(m0, c0, int'(sc), int'(en), int'(md), int'(din), int'(sl), int'(sm), 0, nv, nc);
        m0 = nv; c0 = nc;
        model_step(m80, c80, int'(sc), int'(en), int'(md), int'(din), int'(sl), int'(sm), 128, nv, nc);
        m80 = nv; c80 = nc;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.sync_clear = 0;    bus80.sync_clear = 0;
        bus0.enable = 0;        bus80.enable = 0;
        bus0.mode = 0;          bus80.mode = 0;
        bus0.data_in = 0;       bus80.data_in = 0;
        bus0.serial_in_lsb = 0; bus80.serial_in_lsb = 0;
        bus0.serial_in_msb = 0; bus80.serial_in_msb = 0;
    endtask

    initial begin
        vecs[0]  = '{0, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0, 1};
        vecs[1]  = '{0, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0, 1};
        vecs[2]  = '{0, 1, 3'b001, 8'hA5, 0, 0, 8'hA5, 0, 0};
        vecs[3]  = '{0, 0, 3'b110, 8'h00, 0, 0, 8'hA5, 0, 0};
        vecs[4]  = '{0, 1, 3'b010, 8'h00, 1, 0, 8'h4B, 1, 0};
        vecs[5]  = '{0, 1, 3'b101, 8'h00, 0, 0, 8'hA5, 1, 0};
        vecs[6]  = '{0, 1, 3'b011, 8'h00, 0, 0, 8'h52, 1, 0};
        vecs[7]  = '{0, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0, 0};
        vecs[8]  = '{0, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 0, 0};
        vecs[9]  = '{0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 1, 1};
        vecs[10] = '{0, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 1, 0};
        vecs[11] = '{0, 1, 3'b111, 8'h00, 0, 0, 8'hFE, 0, 0};
        vecs[12] = '{0, 1, 3'b100, 8'h00, 0, 0, 8'hFD, 1, 0};
        vecs[13] = '{0, 1, 3'b000, 8'h00, 1, 1, 8'hFD, 1, 0};
        vecs[14] = '{1, 1, 3'b001, 8'h3C, 0, 0, 8'h00, 0, 1};

        clear_n = 1'b1;
        idle_inputs();
        m0 = 0; c0 = 0; m80 = 128; c80 = 0;

        // asynchronous clear between rising edges
        #10 clear_n = 1'b0;
        #2;
        chk("async_clr_data", 32'(bus0.data_out), 32'h00);
        chk("async_clr_carry", 32'(bus0.carry_out), 32'h0);
        chk("async_clr_zero", 32'(bus0.zero_out), 32'h1);
        chk("async_clr_rv80", 32'(bus80.data_out), 32'h80);
        chk("async_clr_rv80_zero", 32'(bus80.zero_out), 32'h0);
        #8 clear_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].sc, vecs[i].en, vecs[i].md, vecs[i].din, vecs[i].sl, vecs[i].sm);
            chk($sformatf("vec%0d_data", i), 32'(bus0.data_out), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_carry", i), 32'(bus0.carry_out), 32'(vecs[i].exp_carry));
            chk($sformatf("vec%0d_zero", i), 32'(bus0.zero_out), 32'(vecs[i].exp_zero));
            chk($sformatf("vec%0d_rv80_data", i), 32'(bus80.data_out), 32'(m80));
        end
        chk("rv80_sync_clear", 32'(bus80.data_out), 32'h80);
        chk("rv80_sync_carry", 32'(bus80.carry_out), 32'h0);

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic       sc, en, sl, sm;
            logic [2:0] md;
            logic [7:0] din;
            sc  = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 3) != 0);
            md  = 3'($urandom_range(0, 7));
            din = 8'($urandom_range(0, 255));
            sl  = 1'($urandom_range(0, 1));
            sm  = 1'($urandom_range(0, 1));
            apply(sc, en, md, din, sl, sm);
            exp_q.push_back(8'(m0));
            exp_q.push_back(8'(m80));
            chk("rand_data", 32'(bus0.data_out), 32'(exp_q.pop_front()));
            chk("rand_rv80_data", 32'(bus80.data_out), 32'(exp_q.pop_front()));
            chk("rand_carry", 32'(bus0.carry_out), 32'(c0));
            chk("rand_rv80_carry", 32'(bus80.carry_out), 32'(c80));
            chk("rand_zero", 32'(bus0.zero_out), 32'(m0 == 0));
        end

        // clear_n mid-cycle aborts a pending load and holds through a rising edge
        apply(0, 1, 3'b001, 8'h5A, 0, 0);
        @(posedge clock);
        #2 clear_n = 1'b0;
        #1;
        chk("mid_clr_data", 32'(bus0.data_out), 32'h00);
        chk("mid_clr_carry", 32'(bus0.carry_out), 32'h0);
        chk("mid_clr_rv80", 32'(bus80.data_out), 32'h80);
        bus0.data_in = 8'h77; bus80.data_in = 8'h77;
        @(posedge clock);
        #1;
        chk("held_clr_data", 32'(bus0.data_out), 32'h00);
        chk("held_clr_rv80", 32'(bus80.data_out), 32'h80);
        @(negedge clock);
        clear_n = 1'b1;
        idle_inputs();
        m0 = 0; c0 = 0; m80 = 128; c80 = 0;
        apply(0, 1, 3'b110, 8'h00, 0, 0);
        chk("post_clr_inc", 32'(bus0.data_out), 32'h01);
        chk("post_clr_rv80_inc", 32'(bus80.data_out), 32'h81);

        // final report
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
